// File: rtl/mem_bus_arbiter.sv
// Multi-source memory bus: round-robin arbitration into a request FIFO, tagged
// read-response routing back to requesters, per-source outstanding-read throttling.
module mem_bus_arbiter #(
  parameter int NUM_SOURCES     = 4,
  parameter int ADDR_WIDTH      = 32,
  parameter int PAYLOAD_WIDTH   = 64,
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 2,
  localparam int SRC_W = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1,
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_SOURCES-1:0]               req_valid,
  output logic [NUM_SOURCES-1:0]               req_ready,
  input  logic [NUM_SOURCES-1:0]               req_write,
  input  logic [NUM_SOURCES*ADDR_WIDTH-1:0]    req_address,
  input  logic [NUM_SOURCES*PAYLOAD_WIDTH-1:0] req_payload,
  output logic                                 mem_req_valid,
  input  logic                                 mem_req_ready,
  output logic                                 mem_req_write,
  output logic [SRC_W-1:0]                     mem_req_source,
  output logic [ADDR_WIDTH-1:0]                mem_req_address,
  output logic [PAYLOAD_WIDTH-1:0]             mem_req_payload,
  input  logic                                 mem_rsp_valid,
  output logic                                 mem_rsp_ready,
  input  logic [SRC_W-1:0]                     mem_rsp_source,
  input  logic [PAYLOAD_WIDTH-1:0]             mem_rsp_payload,
  output logic [NUM_SOURCES-1:0]               rsp_valid,
  input  logic [NUM_SOURCES-1:0]               rsp_ready,
  output logic [PAYLOAD_WIDTH-1:0]             rsp_payload,
  output logic                                 protocol_error
);

  localparam int PTR_W = $clog2(DEPTH);

  logic                     fifo_write   [DEPTH];
  logic [SRC_W-1:0]         fifo_source  [DEPTH];
  logic [ADDR_WIDTH-1:0]    fifo_address [DEPTH];
  logic [PAYLOAD_WIDTH-1:0] fifo_payload [DEPTH];
  logic [PTR_W-1:0]         wr_ptr, rd_ptr;
  logic [PTR_W:0]           count;
  logic                     full, empty, push, pop;

  logic [CNT_W-1:0]       outstanding [NUM_SOURCES];
  logic [NUM_SOURCES-1:0] eligible, cnt_zero, inc, dec;
  logic [NUM_SOURCES-1:0] grant;
  logic [SRC_W-1:0]       rr_ptr, rr_next, gnt_idx;
  logic                   found;
  logic                   acc_write;
  logic [ADDR_WIDTH-1:0]  acc_address;
  logic [PAYLOAD_WIDTH-1:0] acc_payload;
  logic                   src_ok, src_zero, drop;

  assign full  = (count == (PTR_W+1)'(DEPTH));
  assign empty = (count == '0);

  for (genvar g = 0; g < NUM_SOURCES; g++) begin : g_src
    assign eligible[g]  = req_valid[g] & (req_write[g] | (outstanding[g] < CNT_W'(MAX_OUTSTANDING)));
    assign cnt_zero[g]  = (outstanding[g] == '0);
    assign rsp_valid[g] = mem_rsp_valid & ~drop & (mem_rsp_source == SRC_W'(g));
    assign inc[g]       = grant[g] & ~req_write[g];
    assign dec[g]       = rsp_valid[g] & rsp_ready[g];
  end

  // First eligible source at or after rr_ptr, wrapping; nothing granted while full.
  always_comb begin
    int unsigned idx;
    grant   = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int unsigned k = 0; k < NUM_SOURCES; k++) begin
      idx = (32'(rr_ptr) + k) % 32'(NUM_SOURCES);
      if (!found && eligible[SRC_W'(idx)]) begin
        found   = 1'b1;
        gnt_idx = SRC_W'(idx);
      end
    end
    if (found && !full && !reset) grant[gnt_idx] = 1'b1;
  end

  assign req_ready   = grant;
  assign push        = |grant;
  assign rr_next     = SRC_W'((32'(gnt_idx) + 32'd1) % 32'(NUM_SOURCES));
  assign acc_write   = req_write[gnt_idx];
  assign acc_address = req_address[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
  assign acc_payload = acc_write ? req_payload[gnt_idx*PAYLOAD_WIDTH +: PAYLOAD_WIDTH] : '0;

  assign mem_req_valid   = ~empty;
  assign pop             = mem_req_valid & mem_req_ready;
  assign mem_req_write   = fifo_write[rd_ptr];
  assign mem_req_source  = fifo_source[rd_ptr];
  assign mem_req_address = fifo_address[rd_ptr];
  assign mem_req_payload = fifo_payload[rd_ptr];

  // Responses with an unknown tag or no read in flight are swallowed and flagged.
  assign src_ok        = ({1'b0, mem_rsp_source} < (SRC_W+1)'(NUM_SOURCES));
  assign src_zero      = src_ok ? cnt_zero[mem_rsp_source] : 1'b1;
  assign drop          = mem_rsp_valid & (~src_ok | src_zero);
  assign mem_rsp_ready = (drop | ~src_ok) ? 1'b1 : rsp_ready[mem_rsp_source];
  assign rsp_payload   = mem_rsp_payload;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_write[wr_ptr]   <= acc_write;
      fifo_source[wr_ptr]  <= gnt_idx;
      fifo_address[wr_ptr] <= acc_address;
      fifo_payload[wr_ptr] <= acc_payload;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      rr_ptr         <= '0;
      protocol_error <= 1'b0;
      for (int unsigned i = 0; i < NUM_SOURCES; i++) outstanding[SRC_W'(i)] <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        rr_ptr <= rr_next;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
      for (int unsigned i = 0; i < NUM_SOURCES; i++) begin
        if (inc[SRC_W'(i)] && !dec[SRC_W'(i)])
          outstanding[SRC_W'(i)] <= outstanding[SRC_W'(i)] + CNT_W'(1);
        else if (dec[SRC_W'(i)] && !inc[SRC_W'(i)])
          outstanding[SRC_W'(i)] <= outstanding[SRC_W'(i)] - CNT_W'(1);
      end
      if (drop) protocol_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: response-routing table plus
// hand-written arbitration, full-FIFO, throttling and error sequences.
module tb_mem_bus_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int PW = 64;
  localparam int SW = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req_valid, req_ready, req_write;
  logic [N*AW-1:0]   req_address;
  logic [N*PW-1:0]   req_payload;
  logic              mem_req_valid, mem_req_ready, mem_req_write;
  logic [SW-1:0]     mem_req_source;
  logic [AW-1:0]     mem_req_address;
  logic [PW-1:0]     mem_req_payload;
  logic              mem_rsp_valid, mem_rsp_ready;
  logic [SW-1:0]     mem_rsp_source;
  logic [PW-1:0]     mem_rsp_payload;
  logic [N-1:0]      rsp_valid, rsp_ready;
  logic [PW-1:0]     rsp_payload;
  logic              protocol_error;

  mem_bus_arbiter #(.NUM_SOURCES(N), .ADDR_WIDTH(AW), .PAYLOAD_WIDTH(PW),
                    .DEPTH(4), .MAX_OUTSTANDING(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_address(req_address), .req_payload(req_payload),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_write(mem_req_write), .mem_req_source(mem_req_source),
    .mem_req_address(mem_req_address), .mem_req_payload(mem_req_payload),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready),
    .mem_rsp_source(mem_rsp_source), .mem_rsp_payload(mem_rsp_payload),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_payload(rsp_payload),
    .protocol_error(protocol_error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          w;
    logic [SW-1:0] src;
    logic [AW-1:0] addr;
    logic [PW-1:0] pl;
  } pkt_t;

  typedef struct {
    logic          v;
    logic [SW-1:0] src;
    logic [N-1:0]  rdy;
    logic [PW-1:0] pl;
    logic [N-1:0]  exp_valid;
    logic          exp_mrr;
  } rsp_vec_t;

  pkt_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic w,
                         input logic [AW-1:0] a, input logic [PW-1:0] p);
    req_valid[i] = v;
    req_write[i] = w;
    req_address[i*AW +: AW] = a;
    req_payload[i*PW +: PW] = p;
  endtask

  task automatic expect_push(input logic w, input int src, input logic [AW-1:0] a,
                             input logic [PW-1:0] p);
    pkt_t e;
    e.w    = w;
    e.src  = SW'(src);
    e.addr = a;
    e.pl   = w ? p : '0;
    exp_q.push_back(e);
  endtask

  // Scoreboard: every popped FIFO head must match the oldest expected packet.
  always @(negedge clk) begin
    if (reset === 1'b0 && mem_req_valid === 1'b1 && mem_req_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("mem_req_unexpected", 64'(mem_req_address), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        pkt_t e;
        e = exp_q.pop_front();
        chk("mem_req_write", 64'(mem_req_write), 64'(e.w));
        chk("mem_req_source", 64'(mem_req_source), 64'(e.src));
        chk("mem_req_address", 64'(mem_req_address), 64'(e.addr));
        chk("mem_req_payload", mem_req_payload, e.pl);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  rsp_vec_t tbl [6];
  int       s;

  initial begin
    reset = 1'b1; req_valid = '0; req_write = '0; req_address = '0; req_payload = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_source = '0;
    mem_rsp_payload = '0; rsp_ready = '0;

    tbl[0] = '{1'b1, 2'd0, 4'b0001, 64'h11, 4'b0001, 1'b1};
    tbl[1] = '{1'b1, 2'd1, 4'b1101, 64'h22, 4'b0010, 1'b0};
    tbl[2] = '{1'b1, 2'd3, 4'b1000, 64'h33, 4'b1000, 1'b1};
    tbl[3] = '{1'b1, 2'd2, 4'b1011, 64'h44, 4'b0100, 1'b0};
    tbl[4] = '{1'b0, 2'd1, 4'b0010, 64'h55, 4'b0000, 1'b1};
    tbl[5] = '{1'b0, 2'd2, 4'b0000, 64'h66, 4'b0000, 1'b0};

    // Reset state
    tick();
    req_valid = '1; req_write = '1;
    settle();
    chk("reset_req_ready", 64'(req_ready), 64'h0);
    chk("reset_mem_req_valid", 64'(mem_req_valid), 64'h0);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("reset_protocol_error", 64'(protocol_error), 64'h0);
    req_valid = '0; req_write = '0;
    tick();
    reset = 1'b0;

    // Single read from source 2
    set_req(2, 1'b1, 1'b0, 32'h100, 64'hFFFF);
    settle();
    chk("single_req_ready", 64'(req_ready), 64'b0100);
    expect_push(1'b0, 2, 32'h100, 64'hFFFF);
    tick();
    set_req(2, 1'b0, 1'b0, '0, '0);
    settle();
    chk("single_mem_req_valid", 64'(mem_req_valid), 64'h1);
    chk("single_mem_req_source", 64'(mem_req_source), 64'h2);
    chk("single_mem_req_payload", mem_req_payload, 64'h0);
    mem_req_ready = 1'b1;
    tick();
    mem_rsp_valid = 1'b1; mem_rsp_source = 2'd2; mem_rsp_payload = 64'hDEAD; rsp_ready = 4'b0100;
    settle();
    chk("single_rsp_valid", 64'(rsp_valid), 64'b0100);
    chk("single_rsp_payload", rsp_payload, 64'hDEAD);
    chk("single_mem_rsp_ready", 64'(mem_rsp_ready), 64'h1);
    tick();
    mem_rsp_valid = 1'b0; rsp_ready = '0;

    // One read in flight per source, then the routing table
    for (int i = 0; i < N; i++) begin
      set_req(i, 1'b1, 1'b0, 32'h300 + 32'(i), '0);
      settle();
      chk("setup_req_ready", 64'(req_ready), 64'(1 << i));
      expect_push(1'b0, i, 32'h300 + 32'(i), '0);
      tick();
      set_req(i, 1'b0, 1'b0, '0, '0);
    end
    tick();
    for (int t = 0; t < 6; t++) begin
      mem_rsp_valid = tbl[t].v; mem_rsp_source = tbl[t].src;
      mem_rsp_payload = tbl[t].pl; rsp_ready = tbl[t].rdy;
      settle();
      chk("route_rsp_valid", 64'(rsp_valid), 64'(tbl[t].exp_valid));
      chk("route_mem_rsp_ready", 64'(mem_rsp_ready), 64'(tbl[t].exp_mrr));
      chk("route_rsp_payload", rsp_payload, tbl[t].pl);
    end
    for (int i = 0; i < N; i++) begin
      mem_rsp_valid = 1'b1; mem_rsp_source = SW'(i); rsp_ready = 4'(1 << i);
      settle();
      chk("drain_rsp_valid", 64'(rsp_valid), 64'(1 << i));
      tick();
    end
    mem_rsp_valid = 1'b0; rsp_ready = '0;

    // Round-robin with all four sources holding writes
    for (int i = 0; i < N; i++)
      set_req(i, 1'b1, 1'b1, 32'h2000 + 32'(i*256), 64'hB000 + 64'(i));
    for (int k = 0; k < 8; k++) begin
      s = k % N;
      settle();
      chk("rr_grant", 64'(req_ready), 64'(1 << s));
      expect_push(1'b1, s, 32'h2000 + 32'(s*256 + k/N), 64'hB000 + 64'(s + 16*(k/N)));
      tick();
      set_req(s, 1'b1, 1'b1, 32'h2000 + 32'(s*256 + k/N + 1), 64'hB000 + 64'(s + 16*(k/N + 1)));
    end
    req_valid = '0;
    tick();

    // Full FIFO boundary
    mem_req_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_req(0, 1'b1, 1'b1, 32'h4000 + 32'(k), 64'hC000 + 64'(k));
      settle();
      chk("fill_req_ready", 64'(req_ready), 64'b0001);
      expect_push(1'b1, 0, 32'h4000 + 32'(k), 64'hC000 + 64'(k));
      tick();
    end
    set_req(0, 1'b1, 1'b1, 32'h4004, 64'hC004);
    settle();
    chk("full_req_ready", 64'(req_ready), 64'h0);
    tick();
    chk("full_hold_req_ready", 64'(req_ready), 64'h0);
    mem_req_ready = 1'b1;
    settle();
    chk("full_same_cycle_pop", 64'(req_ready), 64'h0);
    tick();
    mem_req_ready = 1'b0;
    settle();
    chk("full_after_pop_grant", 64'(req_ready), 64'b0001);
    expect_push(1'b1, 0, 32'h4004, 64'hC004);
    tick();
    set_req(0, 1'b0, 1'b0, '0, '0);
    mem_req_ready = 1'b1;
    repeat (5) tick();

    // Outstanding-read limit on source 1
    set_req(1, 1'b1, 1'b0, 32'h500, '0);
    settle();
    chk("limit_read1", 64'(req_ready), 64'b0010);
    expect_push(1'b0, 1, 32'h500, '0);
    tick();
    set_req(1, 1'b1, 1'b0, 32'h501, '0);
    settle();
    chk("limit_read2", 64'(req_ready), 64'b0010);
    expect_push(1'b0, 1, 32'h501, '0);
    tick();
    set_req(1, 1'b1, 1'b0, 32'h502, '0);
    set_req(3, 1'b1, 1'b1, 32'h600, 64'hD00);
    settle();
    chk("limit_other_granted", 64'(req_ready), 64'b1000);
    expect_push(1'b1, 3, 32'h600, 64'hD00);
    tick();
    set_req(3, 1'b0, 1'b0, '0, '0);
    settle();
    chk("limit_held", 64'(req_ready), 64'h0);
    mem_rsp_valid = 1'b1; mem_rsp_source = 2'd1; mem_rsp_payload = 64'hE1; rsp_ready = 4'b0010;
    settle();
    chk("limit_rsp_valid", 64'(rsp_valid), 64'b0010);
    chk("limit_held_during_rsp", 64'(req_ready), 64'h0);
    tick();
    mem_rsp_valid = 1'b0; rsp_ready = '0;
    settle();
    chk("limit_release", 64'(req_ready), 64'b0010);
    expect_push(1'b0, 1, 32'h502, '0);
    tick();
    set_req(1, 1'b0, 1'b0, '0, '0);
    tick();
    for (int r = 0; r < 2; r++) begin
      mem_rsp_valid = 1'b1; mem_rsp_source = 2'd1; rsp_ready = 4'b0010;
      settle();
      chk("limit_drain_rsp", 64'(rsp_valid), 64'b0010);
      tick();
    end
    mem_rsp_valid = 1'b0; rsp_ready = '0;

    // Stray response -> dropped, sticky error
    mem_rsp_valid = 1'b1; mem_rsp_source = 2'd0; mem_rsp_payload = 64'hBAD; rsp_ready = '0;
    settle();
    chk("err_mem_rsp_ready", 64'(mem_rsp_ready), 64'h1);
    chk("err_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("err_before_edge", 64'(protocol_error), 64'h0);
    tick();
    mem_rsp_valid = 1'b0;
    settle();
    chk("err_set", 64'(protocol_error), 64'h1);
    repeat (3) tick();
    chk("err_sticky", 64'(protocol_error), 64'h1);

    // Reset with two reads queued
    mem_req_ready = 1'b0;
    set_req(0, 1'b1, 1'b0, 32'h700, '0);
    tick();
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(2, 1'b1, 1'b0, 32'h702, '0);
    tick();
    set_req(2, 1'b0, 1'b0, '0, '0);
    settle();
    chk("midrst_queued", 64'(mem_req_valid), 64'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    settle();
    chk("midrst_fifo_empty", 64'(mem_req_valid), 64'h0);
    chk("midrst_err_cleared", 64'(protocol_error), 64'h0);
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b1; mem_rsp_source = 2'd0; mem_rsp_payload = 64'h77; rsp_ready = 4'b0001;
    settle();
    chk("midrst_rsp_ready", 64'(mem_rsp_ready), 64'h1);
    chk("midrst_rsp_dropped", 64'(rsp_valid), 64'h0);
    tick();
    mem_rsp_valid = 1'b0; rsp_ready = '0;
    settle();
    chk("midrst_err_set", 64'(protocol_error), 64'h1);
    tick();
    chk("midrst_still_empty", 64'(mem_req_valid), 64'h0);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
